// File: rtl/sseg_rx.sv
// sseg_rx: seven-segment digit receiver.
// Accepts four active-low segment patterns over a valid/ready handshake,
// decodes each to a hex nibble and assembles a 16-bit word (digit 0 in
// [3:0]). A completed word is held with word_valid until the consumer
// takes it. Undecodable patterns store nibble 0 and raise a sticky err
// for the current word. A partial word that sits idle for TIMEOUT cycles
// is discarded (TIMEOUT = 0 disables this).
// Optional build macro SSEG_RX_BLANK_EN: when defined, the blank pattern
// 7F (all segments off) decodes to nibble 0 without raising err.
module sseg_rx #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  segs,
    input  logic        seg_valid,
    output logic        seg_ready,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        out_ready,
    output logic        err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Idle counter is 8 bits; the limit is widened by one bit so that the
    // "counter is about to reach TIMEOUT" compare cannot overflow.
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);
    localparam bit         TO_EN  = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  idle_q, idle_d;
    logic [15:0] word_q, word_d;
    logic        err_q, err_d;

    logic        accept;
    logic        handoff;
    logic        expire;
    logic [4:0]  dec;

    // Returns {bad, nibble}; bad = 1 for any pattern outside the hex table.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h18:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h46:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
`ifdef SSEG_RX_BLANK_EN
            7'h7F:   decode = 5'h00;
`endif
            default: decode = 5'h10;
        endcase
    endfunction

    assign dec     = decode(segs);
    assign accept  = seg_valid && (state_q == COLLECT);
    assign handoff = (state_q == HOLD) && out_ready;
    // Discard fires on the edge where the idle count would reach TIMEOUT;
    // an accept on that same edge takes priority.
    assign expire  = TO_EN && (state_q == COLLECT) && (cnt_q != 2'd0) && !accept
                     && (({1'b0, idle_q} + 9'd1) == TO_LIM);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fourth accepted digit enters HOLD, handoff returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && (cnt_q == 2'd3)) state_d = HOLD;
            HOLD:    if (out_ready)                 state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: ready only while collecting, word valid only while held.
    always_comb begin
        seg_ready  = (state_q == COLLECT);
        word_valid = (state_q == HOLD);
    end

    // Datapath next state: nibble write, digit/idle counters, sticky error.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        idle_d = idle_q;
        if (accept) begin
            word_d[{cnt_q, 2'b00} +: 4] = dec[3:0];
            cnt_d  = cnt_q + 2'd1;
            err_d  = err_q | dec[4];
            idle_d = 8'd0;
        end else if (handoff || expire) begin
            // Word nibbles are kept; only the word-in-progress bookkeeping clears.
            cnt_d  = 2'd0;
            err_d  = 1'b0;
            idle_d = 8'd0;
        end else if ((state_q == COLLECT) && (cnt_q != 2'd0)) begin
            idle_d = idle_q + 8'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= 16'h0000;
            cnt_q  <= 2'd0;
            err_q  <= 1'b0;
            idle_q <= 8'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            idle_q <= idle_d;
        end
    end

    assign word = word_q;
    assign err  = err_q;

endmodule
